// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Every output is registered from the next raster position, so all of them describe the same (hcount,vcount).
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 10
) (
   input  logic          vga_clk,
   input  logic          rst,
   input  logic          pixel_ce,
   output logic          hsync,
   output logic          vsync,
   output logic [CW-1:0] hcount,
   output logic [CW-1:0] vcount,
   output logic          de,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2**CW || V_TOTAL > 2**CW) begin : g_bad_cw
         $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
      end
      if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_mode
         $error("vga_timing_gen: active and sync widths must be at least 1");
      end
   endgenerate

   localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic          h_wrap;
   logic [CW-1:0] h_nxt;
   logic [CW-1:0] v_nxt;

   // vcount steps on the same edge that hcount wraps, so there is no one-cycle lag.
   always_comb begin
      h_wrap = (hcount == H_LAST);
      h_nxt  = h_wrap ? '0 : hcount + CW'(1);
      v_nxt  = vcount;
      if (h_wrap) begin
         v_nxt = (vcount == V_LAST) ? '0 : vcount + CW'(1);
      end
   end

   always_ff @(posedge vga_clk) begin
      if (rst) begin
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         hsync       <= ~HS_POL;
         vsync       <= ~VS_POL;
         de          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (pixel_ce) begin
         hcount      <= h_nxt;
         vcount      <= v_nxt;
         hsync       <= (h_nxt >= HS_FIRST && h_nxt <= HS_LAST) ? HS_POL : ~HS_POL;
         vsync       <= (v_nxt >= VS_FIRST && v_nxt <= VS_LAST) ? VS_POL : ~VS_POL;
         de          <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
         line_start  <= (h_nxt == '0);
         frame_start <= (h_nxt == '0) && (v_nxt == '0);
      end else begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule
